mulchan_wr_arbiter: RTL and testbench
=====================================

// Module: mulchan_wr_arbiter
// PURPOSE
//  Shares the single AXI write master among CH_NUM write-channel controllers.
//  Each controller raises wr_req when its write FIFO holds a full burst; this block grants one channel at a time in round-robin order.
//  It forwards the winner's address and length to the AXI write master and pulses the start strobe.
//  It routes the winner's FIFO read data to the master and holds the grant until the master reports burst completion.
// PARAMETERS
//  CH_NUM     4   number of write channels (2..8)
//  CH_IDX_W   2   log2(CH_NUM), width of the round-robin pointer
//  AXI_WIDTH  64  AXI write data width
// PORTS
//  clk           in   1               AXI master clock, single clock domain
//  rst_n         in   1               asynchronous active-low reset
//  wr_req        in   CH_NUM          per-channel write request
//  wr_addr_bus   in   CH_NUM*30       channel i address at [i*30+:30]
//  wr_len_bus    in   CH_NUM*8        channel i burst length-1 at [i*8+:8]
//  wr_data_bus   in   CH_NUM*AXI_WIDTH  channel i FIFO read data
//  wr_grant      out  CH_NUM          one-hot grant, returned to the channels
//  axi_wr_ready  in   1               AXI write master idle, can accept a start
//  axi_wr_done   in   1               1-cycle pulse: burst (incl. B response) finished
//  axi_wr_start  out  1               1-cycle start pulse to the AXI write master
//  axi_wr_addr   out  30              registered burst start address
//  axi_wr_len    out  8               registered AWLEN (beats-1)
//  axi_wr_data   out  AXI_WIDTH       write data muxed from the granted channel
// BEHAVIOUR
//  Reset: state=IDLE, wr_grant=0, axi_wr_start=0, axi_wr_addr=0, axi_wr_len=0, rr_ptr=0. axi_wr_data=0 while no grant.
//  FSM IDLE->ARB->START->WAIT->IDLE, 2-bit encoding:
//   IDLE : if (|wr_req && axi_wr_ready) ->ARB; otherwise stay.
//   ARB  : pick the first requesting channel at or after rr_ptr (wrap modulo CH_NUM).
//          Register wr_grant one-hot, and latch that channel's addr and len into axi_wr_addr/len.
//          ->START. If wr_req dropped to 0 meanwhile -> IDLE, no grant.
//   START: axi_wr_start=1 for exactly this cycle; ->WAIT.
//   WAIT : hold wr_grant/addr/len. On axi_wr_done: stay granted during the done cycle.
//          Channels update their address on (grant && done). ->IDLE; next cycle wr_grant=0.
//          Then set rr_ptr = winner+1 (mod CH_NUM).
//  Latency: req high with master ready in cycle t -> ARB t+1 -> grant visible t+2 (START) -> start pulse t+2.
//   Minimum gap between consecutive bursts: 3 cycles after the done cycle.
//  axi_wr_data: combinational mux of wr_data_bus by wr_grant, giving zero-latency FIFO data (channels read on axi_writing&grant).
//  wr_req is sampled only in IDLE/ARB. Requests in START/WAIT are ignored, including the owner re-asserting in the done cycle.
//   The owner re-competes in the next IDLE with lowest priority.
//  axi_wr_done outside WAIT is ignored. axi_wr_ready low in IDLE blocks arbitration, and requests stay pending.
//  Simultaneous requests: strict rotating priority from rr_ptr; no channel waits more than CH_NUM-1 bursts.
//  Reset mid-burst (any state): immediately IDLE, grant dropped, no start pulse. Master and channels reset on the same rst_n.
//  rst_n is released through a 2-flop synchronizer on clk (async assert, sync deassert).
// STRUCTURE
//  Shared package: ADDR_W=30, LEN_W=8, arbiter state encodings (IDLE/ARB/START/WAIT).
//  Sub-module rr_pick: combinational round-robin selector (req, ptr) -> one-hot winner + index + valid.
//   The top holds the FSM, pointer, latches and data mux.
// TESTING
//  1 Single req: ch1 req, addr 0x100, len 15 -> grant=4'b0010 two cycles later.
//    axi_wr_start 1 cycle, addr=0x100, len=15. Done -> grant=0 next cycle, rr_ptr=2.
//  2 All 4 req from reset -> grant order ch0,ch1,ch2,ch3,ch0; one start per burst.
//  3 Owner re-request: ch2 re-asserts in its done cycle, ch3 pending -> ch3 granted before ch2.
//  4 Master busy: req while axi_wr_ready=0 for 10 cycles -> no grant until ready=1, then grant within 2 cycles.
//  5 Data mux: distinct constant per channel on wr_data_bus -> axi_wr_data equals granted channel's value, 0 when idle.
//  6 Reset in WAIT: assert rst_n=0 mid-burst -> grant=0, start=0 the same cycle. Ptr=0 after release; spurious done ignored.

Source files
------------

// File: rtl/mulchan_wr_arbiter_pkg.sv
// Shared types and constants for the multi-channel AXI write arbiter.
package mulchan_wr_arbiter_pkg;

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned LEN_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARB   = 2'd1,
      ST_START = 2'd2,
      ST_WAIT  = 2'd3
   } arb_state_e;

   // Burst command handed to the AXI write master.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
   } burst_cmd_t;

endpackage

// File: rtl/mulchan_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping modulo CH_NUM.
module mulchan_wr_arbiter_rr_pick #(
   parameter int unsigned CH_NUM   = 4,
   parameter int unsigned CH_IDX_W = 2
) (
   input  logic [CH_NUM-1:0]   req,
   input  logic [CH_IDX_W-1:0] ptr,
   output logic [CH_NUM-1:0]   onehot_c,
   output logic [CH_IDX_W-1:0] idx_c,
   output logic                valid_c
);

   int unsigned          pos;
   logic [CH_IDX_W-1:0]  k;

   always_comb begin
      onehot_c = '0;
      idx_c    = '0;
      valid_c  = 1'b0;
      pos      = 0;
      k        = '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         pos = 32'(ptr) + i;
         if (pos >= CH_NUM) pos = pos - CH_NUM;
         k = CH_IDX_W'(pos);
         if (!valid_c && req[k]) begin
            valid_c     = 1'b1;
            idx_c       = k;
            onehot_c[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mulchan_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write master among CH_NUM write channels.
module mulchan_wr_arbiter
   import mulchan_wr_arbiter_pkg::*;
#(
   parameter int unsigned CH_NUM    = 4,
   parameter int unsigned CH_IDX_W  = 2,
   parameter int unsigned AXI_WIDTH = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [CH_NUM-1:0]           wr_req,
   input  logic [CH_NUM*ADDR_W-1:0]    wr_addr_bus,
   input  logic [CH_NUM*LEN_W-1:0]     wr_len_bus,
   input  logic [CH_NUM*AXI_WIDTH-1:0] wr_data_bus,
   output logic [CH_NUM-1:0]           wr_grant,
   input  logic                        axi_wr_ready,
   input  logic                        axi_wr_done,
   output logic                        axi_wr_start,
   output logic [ADDR_W-1:0]           axi_wr_addr,
   output logic [LEN_W-1:0]            axi_wr_len,
   output logic [AXI_WIDTH-1:0]        axi_wr_data
);

   // Async assert, synchronous release of the internal reset.
   logic [1:0] rst_sync_q;
   logic       rst_sync_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= '0;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_sync_n = rst_sync_q[1];

   arb_state_e          state_q, state_d;
   logic [CH_NUM-1:0]   grant_q, grant_d;
   logic                start_q, start_d;
   burst_cmd_t          cmd_q, cmd_d;
   logic [CH_IDX_W-1:0] rr_ptr, ptr_d;
   logic [CH_IDX_W-1:0] win_q, win_d;

   logic [CH_NUM-1:0]   pick_onehot_c;
   logic [CH_IDX_W-1:0] pick_idx_c;
   logic                pick_valid_c;
   burst_cmd_t          pick_cmd_c;

   mulchan_wr_arbiter_rr_pick #(
      .CH_NUM   (CH_NUM),
      .CH_IDX_W (CH_IDX_W)
   ) u_rr_pick (
      .req      (wr_req),
      .ptr      (rr_ptr),
      .onehot_c (pick_onehot_c),
      .idx_c    (pick_idx_c),
      .valid_c  (pick_valid_c)
   );

   always_comb begin
      pick_cmd_c.addr = wr_addr_bus[32'(pick_idx_c)*ADDR_W +: ADDR_W];
      pick_cmd_c.len  = wr_len_bus[32'(pick_idx_c)*LEN_W +: LEN_W];
   end

   // Next-state and registered-output values.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      start_d = 1'b0;
      cmd_d   = cmd_q;
      ptr_d   = rr_ptr;
      win_d   = win_q;
      case (state_q)
         ST_IDLE: begin
            if (|wr_req && axi_wr_ready) state_d = ST_ARB;
         end
         ST_ARB: begin
            if (pick_valid_c) begin
               state_d = ST_START;
               grant_d = pick_onehot_c;
               cmd_d   = pick_cmd_c;
               win_d   = pick_idx_c;
               start_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (axi_wr_done) begin
               state_d = ST_IDLE;
               grant_d = '0;
               ptr_d   = (win_q == CH_IDX_W'(CH_NUM - 1)) ? '0 : win_q + CH_IDX_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         start_q <= 1'b0;
         cmd_q   <= '0;
         rr_ptr  <= '0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         start_q <= start_d;
         cmd_q   <= cmd_d;
         rr_ptr  <= ptr_d;
         win_q   <= win_d;
      end
   end

   assign wr_grant     = grant_q;
   assign axi_wr_start = start_q;
   assign axi_wr_addr  = cmd_q.addr;
   assign axi_wr_len   = cmd_q.len;

   // Zero-latency FIFO data path from the granted channel; zero when idle.
   always_comb begin
      axi_wr_data = '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         if (grant_q[i]) axi_wr_data = axi_wr_data | wr_data_bus[i*AXI_WIDTH +: AXI_WIDTH];
      end
   end

endmodule

// File: tb/tb_mulchan_wr_arbiter.sv
// Directed self-checking bench for mulchan_wr_arbiter (4 channels, 64-bit data).
module tb_mulchan_wr_arbiter;

   localparam int unsigned CH_NUM    = 4;
   localparam int unsigned CH_IDX_W  = 2;
   localparam int unsigned AXI_WIDTH = 64;
   localparam int unsigned ADDR_W    = 30;
   localparam int unsigned LEN_W     = 8;

   logic                        clk;
   logic                        rst_n;
   logic [CH_NUM-1:0]           wr_req;
   logic [CH_NUM*ADDR_W-1:0]    wr_addr_bus;
   logic [CH_NUM*LEN_W-1:0]     wr_len_bus;
   logic [CH_NUM*AXI_WIDTH-1:0] wr_data_bus;
   logic [CH_NUM-1:0]           wr_grant;
   logic                        axi_wr_ready;
   logic                        axi_wr_done;
   logic                        axi_wr_start;
   logic [ADDR_W-1:0]           axi_wr_addr;
   logic [LEN_W-1:0]            axi_wr_len;
   logic [AXI_WIDTH-1:0]        axi_wr_data;

   int total  = 0;
   int passed = 0;

   mulchan_wr_arbiter #(
      .CH_NUM    (CH_NUM),
      .CH_IDX_W  (CH_IDX_W),
      .AXI_WIDTH (AXI_WIDTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_req       (wr_req),
      .wr_addr_bus  (wr_addr_bus),
      .wr_len_bus   (wr_len_bus),
      .wr_data_bus  (wr_data_bus),
      .wr_grant     (wr_grant),
      .axi_wr_ready (axi_wr_ready),
      .axi_wr_done  (axi_wr_done),
      .axi_wr_start (axi_wr_start),
      .axi_wr_addr  (axi_wr_addr),
      .axi_wr_len   (axi_wr_len),
      .axi_wr_data  (axi_wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [AXI_WIDTH-1:0] ch_data(input int i);
      return {32'hDA7A_0000 + 32'(i), 32'h1111_1111 * 32'(i + 1)};
   endfunction

   function automatic logic [ADDR_W-1:0] ch_addr(input int i);
      return ADDR_W'(32'h1000 * 32'(i + 1));
   endfunction

   function automatic logic [LEN_W-1:0] ch_len(input int i);
      return LEN_W'(i + 3);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic wait_grant(input int budget);
      int n;
      n = 0;
      while (wr_grant == '0 && n < budget) begin
         tick();
         n++;
      end
      check("grant_seen", 64'(wr_grant != '0), 64'd1);
   endtask

   task automatic finish_burst();
      axi_wr_done = 1'b1;
      tick();
      axi_wr_done = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tick();
   endtask

   initial begin
      rst_n        = 1'b0;
      wr_req       = '0;
      axi_wr_ready = 1'b1;
      axi_wr_done  = 1'b0;
      for (int i = 0; i < int'(CH_NUM); i++) begin
         wr_addr_bus[i*ADDR_W +: ADDR_W]       = ch_addr(i);
         wr_len_bus[i*LEN_W +: LEN_W]          = ch_len(i);
         wr_data_bus[i*AXI_WIDTH +: AXI_WIDTH] = ch_data(i);
      end

      // Reset values
      tick(); tick(); tick();
      check("rst_grant", 64'(wr_grant), 64'd0);
      check("rst_start", 64'(axi_wr_start), 64'd0);
      check("rst_addr", 64'(axi_wr_addr), 64'd0);
      check("rst_len", 64'(axi_wr_len), 64'd0);
      check("rst_data", axi_wr_data, 64'd0);
      rst_n = 1'b1;
      tick(); tick(); tick();

      // 1: single request from ch1, exact latency
      wr_addr_bus[1*ADDR_W +: ADDR_W] = 30'h100;
      wr_len_bus[1*LEN_W +: LEN_W]    = 8'd15;
      wr_req = 4'b0010;
      tick();
      check("t1_arb_nogrant", 64'(wr_grant), 64'd0);
      tick();
      check("t1_grant", 64'(wr_grant), 64'b0010);
      check("t1_start", 64'(axi_wr_start), 64'd1);
      check("t1_addr", 64'(axi_wr_addr), 64'h100);
      check("t1_len", 64'(axi_wr_len), 64'd15);
      check("t1_data", axi_wr_data, ch_data(1));
      wr_req = '0;
      tick();
      check("t1_start_once", 64'(axi_wr_start), 64'd0);
      tick();
      check("t1_hold", 64'(wr_grant), 64'b0010);
      axi_wr_done = 1'b1;
      #1;
      check("t1_done_cycle_grant", 64'(wr_grant), 64'b0010);
      tick();
      axi_wr_done = 1'b0;
      check("t1_released", 64'(wr_grant), 64'd0);
      check("t1_ptr", 64'(dut.rr_ptr), 64'd2);
      check("t1_idle_data", axi_wr_data, 64'd0);
      wr_addr_bus[1*ADDR_W +: ADDR_W] = ch_addr(1);
      wr_len_bus[1*LEN_W +: LEN_W]    = ch_len(1);

      // 2: all channels request from reset -> ch0,ch1,ch2,ch3,ch0
      do_reset();
      wr_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         int e;
         e = k % 4;
         wait_grant(6);
         check("t2_grant", 64'(wr_grant), 64'(1) << e);
         check("t2_start", 64'(axi_wr_start), 64'd1);
         check("t2_addr", 64'(axi_wr_addr), 64'(ch_addr(e)));
         check("t2_len", 64'(axi_wr_len), 64'(ch_len(e)));
         check("t2_data", axi_wr_data, ch_data(e));
         tick();
         check("t2_start_once", 64'(axi_wr_start), 64'd0);
         finish_burst();
         check("t2_released", 64'(wr_grant), 64'd0);
      end
      wr_req = '0;
      tick();

      // 3: owner re-request in done cycle loses to pending ch3 (ptr=1 here)
      wr_req = 4'b0100;
      wait_grant(6);
      check("t3_first", 64'(wr_grant), 64'b0100);
      tick();
      wr_req = 4'b1000;
      tick();
      wr_req = 4'b1100;
      finish_burst();
      check("t3_released", 64'(wr_grant), 64'd0);
      wait_grant(6);
      check("t3_ch3_first", 64'(wr_grant), 64'b1000);
      tick();
      finish_burst();
      wait_grant(6);
      check("t3_ch2_after", 64'(wr_grant), 64'b0100);
      wr_req = '0;
      tick();
      finish_burst();

      // 4: master busy blocks arbitration, request stays pending
      axi_wr_ready = 1'b0;
      wr_req = 4'b0001;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("t4_busy_nogrant", 64'(wr_grant), 64'd0);
      end
      axi_wr_ready = 1'b1;
      tick();
      tick();
      check("t4_grant_after_ready", 64'(wr_grant), 64'b0001);
      check("t4_data", axi_wr_data, ch_data(0));
      wr_req = '0;
      tick();
      finish_burst();
      check("t4_idle_data", axi_wr_data, 64'd0);

      // 6: reset in WAIT, then spurious done and done outside WAIT
      wr_req = 4'b0010;
      wait_grant(6);
      check("t6_grant", 64'(wr_grant), 64'b0010);
      wr_req = '0;
      tick();
      check("t6_wait_hold", 64'(wr_grant), 64'b0010);
      rst_n = 1'b0;
      #1;
      check("t6_rst_grant", 64'(wr_grant), 64'd0);
      check("t6_rst_start", 64'(axi_wr_start), 64'd0);
      check("t6_rst_data", axi_wr_data, 64'd0);
      tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      check("t6_ptr", 64'(dut.rr_ptr), 64'd0);
      finish_burst();
      check("t6_spurious_done", 64'(wr_grant), 64'd0);
      tick();
      check("t6_no_start", 64'(axi_wr_start), 64'd0);
      wr_req = 4'b1000;
      wait_grant(6);
      check("t6_ch3", 64'(wr_grant), 64'b1000);
      wr_req = '0;
      finish_burst();
      check("t6_done_in_start_ignored", 64'(wr_grant), 64'b1000);
      tick();
      tick();
      check("t6_still_held", 64'(wr_grant), 64'b1000);
      finish_burst();
      check("t6_released", 64'(wr_grant), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
